framing_overlap: RTL and testbench

FRAMING_OVERLAP -- requirements
Module: framing_overlap

---
 rtl/framing_pkg.sv | 18 +
 rtl/frame_buf.sv | 37 +++
 rtl/framing_overlap.sv | 224 ++++++++++++++++++++++
 tb/tb_framing_overlap.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/framing_pkg.sv
// Shared definitions for the overlapping framer: FSM state encoding and
// the pointer-width helper used to size the circular buffer addresses.
package framing_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      UNLOAD = 2'd1,
      WAIT   = 2'd2
   } frame_state_e;

   // Address width for a circular buffer holding one frame plus one hop.
   function automatic int ptr_width(input int frame_len, input int hop_len);
      int depth;
      depth = frame_len + hop_len;
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/frame_buf.sv
// Simple dual-port sample store: one write port, one read port, read data
// registered one cycle after the address. Read data holds while re_i is low,
// which the framer relies on to park a fetched sample during a stall.
module frame_buf #(
   parameter int DW    = 9,
   parameter int DEPTH = 384,
   parameter int AW    = 9
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Write port: contents need no reset, stale entries are never read.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port: synchronous read, output register only updates on a fetch.
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/framing_overlap.sv
// Overlapping framer: collects a signed sample stream into a circular buffer
// and replays it as frames of FRAME_LEN samples whose starts are HOP_LEN
// samples apart. Input is never backpressured; a sample that would overwrite
// data still needed is dropped and flagged on the sticky overflow output.
module framing_overlap
   import framing_pkg::*;
#(
   parameter int I_BW      = 9,
   parameter int O_BW      = 16,
   parameter int FRAME_LEN = 256,
   parameter int HOP_LEN   = 128
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic [I_BW-1:0] data_i,
   input  logic            valid_i,
   output logic [O_BW-1:0] data_o,
   output logic            valid_o,
   input  logic            ready_i,
   output logic            last_o,
   output logic            overflow_o
);

   localparam int DEPTH = FRAME_LEN + HOP_LEN;
   localparam int PW    = ptr_width(FRAME_LEN, HOP_LEN);
   localparam int CW    = $clog2(FRAME_LEN + 1);

   localparam logic [PW:0]   DEPTH_P   = (PW+1)'(DEPTH);
   localparam logic [PW:0]   HOP_P     = (PW+1)'(HOP_LEN);
   localparam logic [CW-1:0] FRAME_C   = CW'(FRAME_LEN);
   localparam logic [CW-1:0] HOP_C     = CW'(HOP_LEN);
   localparam logic [CW-1:0] FETCH_C   = CW'(FRAME_LEN - 1);

   if (HOP_LEN > FRAME_LEN || HOP_LEN < 1 || FRAME_LEN < 2 || O_BW < I_BW) begin : g_bad_params
      $error("framing_overlap: illegal parameters (need 1 <= HOP_LEN <= FRAME_LEN, FRAME_LEN >= 2, O_BW >= I_BW)");
   end

   // Modulo-DEPTH pointer advance; the sum never reaches twice the depth.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [PW:0] n);
      logic [PW:0] s;
      s = {1'b0, p} + n;
      if (s >= DEPTH_P) begin
         s = s - DEPTH_P;
      end
      return s[PW-1:0];
   endfunction

   frame_state_e    state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   base_q, base_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   new_cnt_q, new_cnt_d;
   logic [CW-1:0]   fetch_left_q, fetch_left_d;
   logic            p1_valid_q, p1_valid_d;
   logic            p1_last_q, p1_last_d;
   logic            valid_q, valid_d;
   logic            last_q, last_d;
   logic [O_BW-1:0] data_q, data_d;
   logic            overflow_q, overflow_d;

   logic            clear;
   logic [CW-1:0]   target;
   logic            room;
   logic            accept;
   logic            drop;
   logic [CW-1:0]   new_cnt_inc;
   logic            reached;
   logic            out_fire;
   logic            last_hs;
   logic            out_load;
   logic            start_fetch;
   logic            issue_more;
   logic            rd_en;
   logic [PW-1:0]   rd_addr;
   logic [I_BW-1:0] rd_data;

   assign clear       = rst_i | ~en_i;
   assign target      = (state_q == FILL) ? FRAME_C : HOP_C;
   assign room        = new_cnt_q < target;
   assign accept      = ~rst_i & en_i & valid_i & room;
   assign drop        = ~rst_i & en_i & valid_i & ~room;
   assign new_cnt_inc = new_cnt_q + CW'(accept);
   assign reached     = (new_cnt_inc == target);
   assign out_fire    = valid_q & ready_i;
   assign last_hs     = out_fire & last_q;
   assign out_load    = p1_valid_q & (~valid_q | ready_i);

   // Frame sequencing: a frame starts fetching in the very cycle its last
   // input sample is accepted (or at the previous frame's last handshake),
   // and the new-sample count restarts for the following frame.
   always_comb begin
      state_d     = state_q;
      new_cnt_d   = new_cnt_inc;
      start_fetch = 1'b0;
      case (state_q)
         FILL, WAIT: begin
            if (reached) begin
               state_d     = UNLOAD;
               start_fetch = 1'b1;
            end
         end
         UNLOAD: begin
            if (last_hs) begin
               if (reached) begin
                  state_d     = UNLOAD;
                  start_fetch = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         default: state_d = FILL;
      endcase
      if (start_fetch) begin
         new_cnt_d = '0;
      end
   end

   // Write side and frame base: the base moves one hop once a frame is fully
   // delivered, so the next frame's fetch address is the updated base.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      base_d     = base_q;
      overflow_d = overflow_q | drop;
      if (accept) begin
         wr_ptr_d = ptr_add(wr_ptr_q, (PW+1)'(1));
      end
      if (last_hs) begin
         base_d = ptr_add(base_q, HOP_P);
      end
   end

   // Fetch pipeline: issue a read only when the single in-flight slot will be
   // free next cycle, so a stall parks data in the RAM output without loss.
   always_comb begin
      issue_more   = (fetch_left_q != '0) & (~p1_valid_q | out_load);
      rd_en        = start_fetch | issue_more;
      rd_addr      = start_fetch ? base_d : rd_ptr_q;
      rd_ptr_d     = rd_en ? ptr_add(rd_addr, (PW+1)'(1)) : rd_ptr_q;
      fetch_left_d = fetch_left_q;
      p1_valid_d   = p1_valid_q;
      p1_last_d    = p1_last_q;
      if (start_fetch) begin
         fetch_left_d = FETCH_C;
      end else if (issue_more) begin
         fetch_left_d = fetch_left_q - CW'(1);
      end
      if (rd_en) begin
         p1_valid_d = 1'b1;
         p1_last_d  = ~start_fetch & (fetch_left_q == CW'(1));
      end else if (out_load) begin
         p1_valid_d = 1'b0;
      end
   end

   // Output register: load the fetched sample sign-extended, zero the bus
   // when nothing is pending, and hold everything while the sink stalls.
   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      if (out_load) begin
         valid_d = 1'b1;
         last_d  = p1_last_q;
         data_d  = O_BW'($signed(rd_data));
      end else if (out_fire) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
         data_d  = '0;
      end
   end

   // State registers; reset and disable both abort any frame in progress.
   always_ff @(posedge clk_i) begin
      if (clear) begin
         state_q      <= FILL;
         wr_ptr_q     <= '0;
         base_q       <= '0;
         rd_ptr_q     <= '0;
         new_cnt_q    <= '0;
         fetch_left_q <= '0;
         p1_valid_q   <= 1'b0;
         p1_last_q    <= 1'b0;
         valid_q      <= 1'b0;
         last_q       <= 1'b0;
         data_q       <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         base_q       <= base_d;
         rd_ptr_q     <= rd_ptr_d;
         new_cnt_q    <= new_cnt_d;
         fetch_left_q <= fetch_left_d;
         p1_valid_q   <= p1_valid_d;
         p1_last_q    <= p1_last_d;
         valid_q      <= valid_d;
         last_q       <= last_d;
         data_q       <= data_d;
         overflow_q   <= overflow_d;
      end
   end

   frame_buf #(
      .DW    (I_BW),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_buf (
      .clk_i   (clk_i),
      .we_i    (accept),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_i),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign last_o     = last_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_framing_overlap.sv
// Directed bench for framing_overlap: an overlapping instance (frame 8, hop 4)
// and a non-overlapping one (frame 8, hop 8) share clock, reset, data and
// ready; each has its own valid input and its own handshake log.
module tb_framing_overlap;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        ready;
   logic [8:0]  dataIn;
   logic        validA, validB;
   logic [15:0] dataA, dataB;
   logic        validOA, validOB;
   logic        lastA, lastB;
   logic        ovfA, ovfB;

   int checks = 0;
   int errors = 0;

   logic [15:0] qDataA [$];
   logic [15:0] qDataB [$];
   bit          qLastA [$];
   bit          qLastB [$];

   always #5 clock = ~clock;

   framing_overlap #(.I_BW(9), .O_BW(16), .FRAME_LEN(8), .HOP_LEN(4)) dutA (
      .clk_i(clock), .rst_i(reset), .en_i(enable), .data_i(dataIn), .valid_i(validA),
      .data_o(dataA), .valid_o(validOA), .ready_i(ready), .last_o(lastA), .overflow_o(ovfA)
   );

   framing_overlap #(.I_BW(9), .O_BW(16), .FRAME_LEN(8), .HOP_LEN(8)) dutB (
      .clk_i(clock), .rst_i(reset), .en_i(enable), .data_i(dataIn), .valid_i(validB),
      .data_o(dataB), .valid_o(validOB), .ready_i(ready), .last_o(lastB), .overflow_o(ovfB)
   );

   // Log every output handshake, sampled mid-cycle away from the clock edge.
   always @(negedge clock) begin
      if (validOA && ready) begin
         qDataA.push_back(dataA);
         qLastA.push_back(lastA);
      end
      if (validOB && ready) begin
         qDataB.push_back(dataB);
         qLastB.push_back(lastB);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input bit toB, input logic [8:0] value);
      dataIn = value;
      validA = !toB;
      validB = toB;
      step();
      validA = 1'b0;
      validB = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic resetDut();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      qDataA.delete();
      qLastA.delete();
      qDataB.delete();
      qLastB.delete();
   endtask

   task automatic waitOutputs(input bit onB, input int n, input int budget, input string tag);
      int cnt = 0;
      while (((onB ? qDataB.size() : qDataA.size()) < n) && (cnt < budget)) begin
         step();
         cnt++;
      end
      checkOutput(tag, onB ? qDataB.size() : qDataA.size(), n);
   endtask

   task automatic checkFrames(input bit onB, input int nFrames, input int hop, input int base, input string tag);
      for (int k = 0; k < nFrames; k++) begin
         for (int j = 0; j < 8; j++) begin
            int idx;
            logic [15:0] obsData;
            bit obsLast;
            idx     = k * 8 + j;
            obsData = onB ? qDataB[idx] : qDataA[idx];
            obsLast = onB ? qLastB[idx] : qLastA[idx];
            checkOutput($sformatf("%s_f%0d_s%0d_data", tag, k, j), obsData, 16'(base + k * hop + j));
            checkOutput($sformatf("%s_f%0d_s%0d_last", tag, k, j), obsLast, (j == 7) ? 1 : 0);
         end
      end
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      ready  = 1'b0;
      validA = 1'b0;
      validB = 1'b0;
      dataIn = '0;
      step();
      step();
      checkOutput("resetValidA", validOA, 0);
      checkOutput("resetLastA", lastA, 0);
      checkOutput("resetDataA", dataA, 0);
      checkOutput("resetOvfA", ovfA, 0);
      checkOutput("resetValidB", validOB, 0);
      reset = 1'b0;

      $display("[TB] overlap scenario: frame 8 hop 4, ramp 0..15");
      resetDut();
      ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 9'(i));
         if (i == 7) checkOutput("overlapLatencyIdle", validOA, 0);
         if (i == 8) begin
            checkOutput("overlapLatencyRise", validOA, 1);
            checkOutput("overlapFirstSample", dataA, 0);
         end
      end
      waitOutputs(1'b0, 8, 40, "overlapFrame0Count");
      for (int i = 12; i < 16; i++) applyStimulus(1'b0, 9'(i));
      waitOutputs(1'b0, 24, 60, "overlapAllCount");
      checkFrames(1'b0, 3, 4, 0, "overlap");
      repeat (6) step();
      checkOutput("overlapNoExtra", qDataA.size(), 24);
      checkOutput("overlapNoOverflow", ovfA, 0);

      $display("[TB] no-overlap scenario: frame 8 hop 8, ramp 0..23");
      resetDut();
      ready = 1'b1;
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 9'(i));
      waitOutputs(1'b1, 8, 40, "noOverlapFrame0Count");
      for (int i = 16; i < 24; i++) applyStimulus(1'b1, 9'(i));
      waitOutputs(1'b1, 24, 60, "noOverlapAllCount");
      checkFrames(1'b1, 3, 8, 0, "noOverlap");
      repeat (6) step();
      checkOutput("noOverlapNoExtra", qDataB.size(), 24);
      checkOutput("noOverlapNoOverflow", ovfB, 0);

      $display("[TB] backpressure scenario");
      resetDut();
      ready = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 9'(100 + i));
      step();
      checkOutput("bpFirstValid", validOA, 1);
      checkOutput("bpFirstData", dataA, 100);
      step();
      checkOutput("bpSecondData", dataA, 101);
      ready = 1'b0;
      step();
      checkOutput("bpStall1Data", dataA, 101);
      checkOutput("bpStall1Valid", validOA, 1);
      checkOutput("bpStall1Last", lastA, 0);
      step();
      checkOutput("bpStall2Data", dataA, 101);
      ready = 1'b1;
      step();
      checkOutput("bpResumeData", dataA, 102);
      waitOutputs(1'b0, 8, 40, "bpCount");
      checkFrames(1'b0, 1, 4, 100, "bp");

      $display("[TB] overflow scenario");
      resetDut();
      ready = 1'b0;
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 9'(i));
      checkOutput("ovfBeforeDrop", ovfA, 0);
      applyStimulus(1'b0, 9'(12));
      checkOutput("ovfAfterDrop", ovfA, 1);
      step();
      checkOutput("ovfSticky", ovfA, 1);
      ready = 1'b1;
      waitOutputs(1'b0, 16, 60, "ovfCount");
      checkFrames(1'b0, 2, 4, 0, "ovf");
      repeat (6) step();
      checkOutput("ovfNoThirdFrame", qDataA.size(), 16);
      checkOutput("ovfStillSet", ovfA, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("ovfClearedByReset", ovfA, 0);

      $display("[TB] sign extension scenario");
      resetDut();
      ready = 1'b1;
      applyStimulus(1'b0, 9'h100);
      applyStimulus(1'b0, 9'h0FF);
      for (int i = 2; i < 8; i++) applyStimulus(1'b0, 9'(i));
      waitOutputs(1'b0, 8, 40, "signCount");
      checkOutput("signNeg256", qDataA[0], 16'hFF00);
      checkOutput("signPos255", qDataA[1], 16'h00FF);
      checkOutput("signLastFlag", qLastA[7], 1);
      step();
      checkOutput("idleValid", validOA, 0);
      checkOutput("idleDataZero", dataA, 0);

      $display("[TB] reset mid-frame scenario");
      resetDut();
      ready = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 9'(50 + i));
      step();
      step();
      step();
      checkOutput("midThirdSample", dataA, 52);
      reset = 1'b1;
      step();
      checkOutput("midAbortValid", validOA, 0);
      reset = 1'b0;
      qDataA.delete();
      qLastA.delete();
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 9'(200 + i));
      checkOutput("midRefillQuiet", qDataA.size(), 0);
      waitOutputs(1'b0, 8, 40, "midCount");
      checkFrames(1'b0, 1, 4, 200, "mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
